// File: rtl/ser_tx6.sv
// Frame transmitter: start bit, WIDTH data bits MSB-first, optional even parity, stop bit.
// Define SER_TX6_PARITY_EN to insert the parity bit between the last data bit and the stop bit.
module ser_tx6 #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    output logic             rdy,
    output logic             busy,
    output logic             sout,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
`ifdef SER_TX6_PARITY_EN
        PAR   = 3'd3,
`endif
        STOP  = 3'd4
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] shift_r;
    logic [CW-1:0]    cnt_r;
    logic             sout_r;
    logic             rdy_r;
    logic             busy_r;
    logic             done_r;

`ifdef SER_TX6_PARITY_EN
    logic             par_r;

    function automatic logic even_parity(input logic [WIDTH-1:0] w);
        return ^w;
    endfunction

    // Parity of the captured word, taken at load so d may change afterwards.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            par_r <= 1'b0;
        end else if (rdy_r && ld) begin
            par_r <= even_parity(d);
        end else begin
            par_r <= par_r;
        end
    end
`endif

    // Frame sequencer; outputs are registered from the next state so sout never sees ld or d directly.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_r <= IDLE;
            shift_r <= {WIDTH{1'b0}};
            cnt_r   <= CNT_ZERO;
            sout_r  <= 1'b1;
            rdy_r   <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (ld) begin
                        shift_r <= d;
                        state_r <= START;
                        sout_r  <= 1'b0;
                        rdy_r   <= 1'b0;
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                    end else begin
                        sout_r  <= 1'b1;
                        rdy_r   <= 1'b1;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b0;
                    end
                end
                START: begin
                    cnt_r   <= CNT_LAST;
                    state_r <= DATA;
                    sout_r  <= shift_r[WIDTH-1];
                    rdy_r   <= 1'b0;
                    busy_r  <= 1'b1;
                    done_r  <= 1'b0;
                end
                DATA: begin
                    shift_r <= {shift_r[WIDTH-2:0], 1'b0};
                    if (cnt_r == CNT_ZERO) begin
`ifdef SER_TX6_PARITY_EN
                        state_r <= PAR;
                        sout_r  <= par_r;
                        rdy_r   <= 1'b0;
                        done_r  <= 1'b0;
`else
                        state_r <= STOP;
                        sout_r  <= 1'b1;
                        rdy_r   <= 1'b1;
                        done_r  <= 1'b1;
`endif
                    end else begin
                        // The bit after the current MSB is the one that goes out next.
                        cnt_r   <= cnt_r - CNT_ONE;
                        sout_r  <= shift_r[WIDTH-2];
                        rdy_r   <= 1'b0;
                        done_r  <= 1'b0;
                    end
                    busy_r <= 1'b1;
                end
`ifdef SER_TX6_PARITY_EN
                PAR: begin
                    state_r <= STOP;
                    sout_r  <= 1'b1;
                    rdy_r   <= 1'b1;
                    busy_r  <= 1'b1;
                    done_r  <= 1'b1;
                end
`endif
                STOP: begin
                    if (ld) begin
                        shift_r <= d;
                        state_r <= START;
                        sout_r  <= 1'b0;
                        rdy_r   <= 1'b0;
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                    end else begin
                        state_r <= IDLE;
                        sout_r  <= 1'b1;
                        rdy_r   <= 1'b1;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    shift_r <= {WIDTH{1'b0}};
                    cnt_r   <= CNT_ZERO;
                    sout_r  <= 1'b1;
                    rdy_r   <= 1'b1;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign sout = sout_r;
    assign rdy  = rdy_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: doc/ser_tx6.md
# ser_tx6

Parallel-to-serial frame transmitter that sits directly downstream of the 6-bit left-shift register stage. On a load request it captures a WIDTH-bit word, for example the register's `q[5:0]`, and shifts it out MSB-first on a single line. The frame is one start bit, WIDTH data bits, an optional parity bit and one stop bit. A ready/load handshake lets the upstream stage know when a new word can be taken.

## Interface
Parameters:
- WIDTH, 6, data word width; legal range 2..16.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- clear  input  1  reset; asynchronous and active-low.
- ld  input  1  load request; sampled on the rising edge; effective only when rdy=1.
- d  input  WIDTH  parallel word to transmit; sampled on the same edge as an accepted ld.
- rdy  output  1  block can accept a word this cycle.
- busy  output  1  a frame is in progress (START, DATA, PAR or STOP).
- sout  output  1  serial line; idle level is 1; registered.
- done  output  1  one-cycle pulse, high during the stop-bit cycle.

## Operation
- States: IDLE, START, DATA, PAR (present only with the parity macro), STOP. The state register and the shift register are cleared by the asynchronous reset.
- Reset (clear=0), applied immediately and asynchronously:
  - state=IDLE, shift register=0, bit counter=0, parity accumulator=0.
  - sout=1, rdy=1, busy=0, done=0.
- rdy=1 in IDLE and STOP, 0 otherwise. busy=1 in any state except IDLE.
- IDLE: an edge with ld=1 and rdy=1 captures d into the shift register and moves to START. With ld=0 the block stays in IDLE and sout stays 1.
- START: sout=0 for one cycle. The bit counter loads WIDTH-1, then the block moves to DATA.
- DATA:
  - sout = shift register MSB.
  - Each edge shifts the register left by one (0 enters the LSB) and decrements the counter.
  - When the counter is 0, the next state is PAR if the macro is defined, otherwise STOP.
- PAR: sout = even-parity bit (XOR of all WIDTH captured bits); one cycle, then STOP.
- STOP: sout=1 and done=1 for one cycle.
  - If ld=1 at the closing edge, d is captured and the next state is START, giving back-to-back frames with no idle gap.
  - Otherwise the next state is IDLE.
- ld during START, DATA or PAR is ignored. d changes during a frame have no effect.
- The bit counter is $clog2(WIDTH) bits wide and never wraps within a frame.

## Timing
- ld accepted at edge N gives this sout sequence:
  - cycle N+1: start bit (0).
  - cycles N+2 .. N+1+WIDTH: data, d[WIDTH-1] first.
  - next cycle: parity bit, if enabled.
  - next cycle: stop bit (1) with done=1.
- Frame length is WIDTH+2 cycles (8 for WIDTH=6), or WIDTH+3 with parity (9).
- Minimum gap between accepted loads equals the frame length.
- Outputs are registered or state-decoded only. There is no combinational path from ld or d to sout.
- clear asserted mid-frame aborts the frame: sout returns to 1 at once and no done pulse is produced. The first ld after clear rises starts a clean frame.
- Simultaneous clear=0 and ld=1: reset wins and the word is discarded.

## Configuration
- SER_TX6_PARITY_EN defined:
  - PAR state present; even-parity bit inserted between the last data bit and the stop bit.
  - Frame is WIDTH+3 cycles.
- SER_TX6_PARITY_EN undefined:
  - PAR state and the parity logic are absent.
  - DATA goes directly to STOP; frame is WIDTH+2 cycles.

## Test plan
- Reset: clear=0 with ld=1 and d=6'b111111 held -> sout=1, rdy=1, busy=0, done=0 throughout. After release with ld=0, the block stays idle.
- Single frame, no parity: d=6'b101100, ld pulsed for 1 cycle ->
  - sout over 8 cycles = 0,1,0,1,1,0,0,1.
  - rdy=0 for cycles 1-7; done=1 only in cycle 8.
  - Back to IDLE after the frame.
- Load while busy: ld held high with d changing to 6'b010101 during the DATA of frame 6'b110011 -> transmitted bits stay 1,1,0,0,1,1.
- Back-to-back: ld=1 with d=6'b000001 in the stop cycle of a frame -> the next cycle is a start bit, followed by data 0,0,0,0,0,1; no idle cycle between frames.
- Reset mid-frame: clear=0 during the 3rd data bit -> sout=1, busy=0 and no done pulse. A new ld with d=6'b111000 after release gives the full frame 0,1,1,1,0,0,0,1.
- With SER_TX6_PARITY_EN:
  - d=6'b101100 -> parity bit 1; frame 0,1,0,1,1,0,0,1,1 (9 cycles).
  - d=6'b110000 -> parity bit 0.
